// File: rtl/xconverter_upsize.sv
// Narrow-to-wide packer: gathers DWM narrow beats (or fewer, on slast) into one
// wide word held in a single flow-through output register with valid/ready on both sides.
module xconverter_upsize #(
  parameter int DWIDTH_S = 32,
  parameter int DWIDTH_D = 256,
  parameter int DWADDR   = 32
) (
  input  logic                    xclk,
  input  logic                    xreset_n,
  input  logic                    svalid,
  output logic                    sready,
  input  logic [DWIDTH_S-1:0]     sdata,
  input  logic [DWIDTH_S/8-1:0]   swstrb,
  input  logic [DWADDR-1:0]       saddr,
  input  logic                    slast,
  output logic                    mvalid,
  input  logic                    mready,
  output logic [DWIDTH_D-1:0]     mdata,
  output logic [DWIDTH_D/8-1:0]   mwstrb,
  output logic [DWADDR-1:0]       maddr
);

  localparam int DWM    = DWIDTH_D / DWIDTH_S;
  localparam int CWIDTH = $clog2(DWM);
  localparam int SSTRB  = DWIDTH_S / 8;

  logic [CWIDTH-1:0]     cnt_q, cnt_d;
  logic                  mvalid_q, mvalid_d;
  logic [DWIDTH_D-1:0]   mdata_q, mdata_d;
  logic [DWIDTH_D/8-1:0] mwstrb_q, mwstrb_d;
  logic [DWADDR-1:0]     maddr_q, maddr_d;

  logic accept;
  logic complete;

  // The holding register may be refilled in the same cycle it drains.
  assign sready   = ~mvalid_q | mready;
  assign accept   = svalid & sready;
  assign complete = accept & (slast | (cnt_q == CWIDTH'(DWM - 1)));

  always_comb begin
    cnt_d    = cnt_q;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    mwstrb_d = mwstrb_q;
    maddr_d  = maddr_q;

    if (mvalid_q && mready)
      mvalid_d = 1'b0;

    if (accept) begin
      // The first beat of a word starts from a clean register.
      if (cnt_q == '0) begin
        mdata_d  = '0;
        mwstrb_d = '0;
        maddr_d  = saddr;
      end
      for (int i = 0; i < DWM; i++) begin
        if (cnt_q == CWIDTH'(i)) begin
          mdata_d[i*DWIDTH_S +: DWIDTH_S] = sdata;
          mwstrb_d[i*SSTRB +: SSTRB]      = swstrb;
        end
      end
      if (complete) begin
        cnt_d    = '0;
        mvalid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge xclk or negedge xreset_n) begin
    if (!xreset_n) begin
      cnt_q    <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mwstrb_q <= '0;
      maddr_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mwstrb_q <= mwstrb_d;
      maddr_q  <= maddr_d;
    end
  end

  assign mvalid = mvalid_q;
  assign mdata  = mdata_q;
  assign mwstrb = mwstrb_q;
  assign maddr  = maddr_q;

endmodule
